// File: rtl/sub_serial_nib.sv
// Nibble-serial subtractor: Diff = A - B, one 4-bit nibble per clock, LSB first.
// Optional saturation of signed overflow is enabled by defining SUB_SAT_EN.

module add_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module sub_serial_nib #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovfl,
    output logic             Zero,
    output logic             Neg
);
    localparam int STEPS = WIDTH / 4;
    localparam int IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(STEPS - 1);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, a_next;
    logic [WIDTH-1:0]  b_reg, b_next;
    logic [WIDTH-1:0]  work_reg, work_next;
    logic [WIDTH-1:0]  diff_reg, diff_next;
    logic [IDXW-1:0]   idx_reg, idx_next;
    logic              carry_reg, carry_next;
    logic              bout_reg, bout_next;
    logic              ovfl_reg, ovfl_next;
    logic              zero_reg, zero_next;
    logic              neg_reg, neg_next;

    logic [3:0]        a_nibs [STEPS];
    logic [3:0]        nb_nibs [STEPS];
    logic [3:0]        a_nib, nb_nib, sum_nib;
    logic              cout_nib;
    logic [WIDTH-1:0]  raw_diff;
    logic [WIDTH-1:0]  final_diff;
    logic              ovfl_raw;

    // Subtraction as A + ~B + carry: the inverted subtrahend is prepared per nibble.
    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_nib
            assign a_nibs[gi]  = a_reg[4*gi +: 4];
            assign nb_nibs[gi] = ~b_reg[4*gi +: 4];
        end
    endgenerate

    assign a_nib  = a_nibs[idx_reg];
    assign nb_nib = nb_nibs[idx_reg];

    add_4bit u_add (
        .a    (a_nib),
        .b    (nb_nib),
        .cin  (carry_reg),
        .sum  (sum_nib),
        .cout (cout_nib)
    );

    // Working result with the current nibble merged in.
    always_comb begin
        raw_diff = work_reg;
        for (int i = 0; i < STEPS; i++) begin
            if (idx_reg == IDXW'(i)) begin
                raw_diff[4*i +: 4] = sum_nib;
            end
        end
    end

    assign ovfl_raw = (a_reg[MSB] != b_reg[MSB]) && (raw_diff[MSB] != a_reg[MSB]);

`ifdef SUB_SAT_EN
    // A negative minuend can only overflow downward, a positive one upward.
    assign final_diff = !ovfl_raw ? raw_diff :
                        (a_reg[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign final_diff = raw_diff;
`endif

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        work_next  = work_reg;
        diff_next  = diff_reg;
        idx_next   = idx_reg;
        carry_next = carry_reg;
        bout_next  = bout_reg;
        ovfl_next  = ovfl_reg;
        zero_next  = zero_reg;
        neg_next   = neg_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    a_next     = A;
                    b_next     = B;
                    idx_next   = '0;
                    carry_next = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                work_next  = raw_diff;
                carry_next = cout_nib;
                idx_next   = idx_reg + 1'b1;
                if (idx_reg == LAST_IDX) begin
                    diff_next  = final_diff;
                    bout_next  = ~cout_nib;
                    ovfl_next  = ovfl_raw;
                    zero_next  = (final_diff == '0);
                    neg_next   = final_diff[MSB];
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            work_reg  <= '0;
            diff_reg  <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b1;
            bout_reg  <= 1'b0;
            ovfl_reg  <= 1'b0;
            zero_reg  <= 1'b0;
            neg_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            work_reg  <= work_next;
            diff_reg  <= diff_next;
            idx_reg   <= idx_next;
            carry_reg <= carry_next;
            bout_reg  <= bout_next;
            ovfl_reg  <= ovfl_next;
            zero_reg  <= zero_next;
            neg_reg   <= neg_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign Diff = diff_reg;
    assign Bout = bout_reg;
    assign Ovfl = ovfl_reg;
    assign Zero = zero_reg;
    assign Neg  = neg_reg;

endmodule

// File: tb/tb_sub_serial_nib.sv
// Bench for sub_serial_nib: spec vector table, held-start stream, busy-ignore
// and mid-run reset, with a latency-tagged scoreboard.

module tb_sub_serial_nib;
    localparam int WIDTH = 16;
    localparam int STEPS = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done, bout, ovfl, zero, neg;
    logic [WIDTH-1:0] diff;

    sub_serial_nib #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .Diff  (diff),
        .Bout  (bout),
        .Ovfl  (ovfl),
        .Zero  (zero),
        .Neg   (neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] diff;
        logic        bout;
        logic        ovfl;
        logic        zero;
        logic        neg;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } pend_t;

    pend_t sbq[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    model_run = 0;
    vec_t  tbl[9];
    vec_t  nop;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    function automatic vec_t model(input logic [15:0] av, input logic [15:0] bv);
        vec_t        v;
        int          sd;
        logic [16:0] w;
        w = {1'b0, av} - {1'b0, bv};
        sd = int'($signed(av)) - int'($signed(bv));
        v.a = av;
        v.b = bv;
        v.bout = w[16];
        v.ovfl = (sd > 32767) || (sd < -32768);
        v.diff = w[15:0];
`ifdef SUB_SAT_EN
        if (v.ovfl) v.diff = (sd > 0) ? 16'h7FFF : 16'h8000;
`endif
        v.zero = (v.diff == 16'h0000);
        v.neg = v.diff[15];
        return v;
    endfunction

    // One clock of stimulus; the FSM timing model decides whether start is taken.
    task automatic step(input logic s, input vec_t v);
        @(negedge clk);
        start = s;
        a = v.a;
        b = v.b;
        if (s && model_run == 0) sbq.push_back('{v, cyc + 1});
        @(posedge clk);
        if (model_run > 0) model_run--;
        else if (s) model_run = STEPS;
    endtask

    task automatic drain();
        for (int k = 0; k < 4 * STEPS + 8 && sbq.size() > 0; k++) step(1'b0, nop);
        step(1'b0, nop);
    endtask

    // Monitor: every done pulse must match the oldest expected result, on time.
    pend_t mon_p;
    logic  width_chk = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (width_chk) check("done_width", {63'b0, done}, 64'd0);
            width_chk = 1'b0;
            if (done) begin
                if (sbq.size() == 0) begin
                    check("spurious_done", 64'd1, 64'd0);
                end else begin
                    mon_p = sbq.pop_front();
                    check("latency", 64'(cyc - mon_p.acc), 64'(STEPS));
                    check($sformatf("result %h-%h {diff,bout,ovfl,zero,neg,busy}", mon_p.v.a, mon_p.v.b),
                          {43'b0, diff, bout, ovfl, zero, neg, busy},
                          {43'b0, mon_p.v.diff, mon_p.v.bout, mon_p.v.ovfl, mon_p.v.zero, mon_p.v.neg, 1'b0});
                    width_chk = 1'b1;
                end
            end else if (sbq.size() > 0 && (cyc - sbq[0].acc) > STEPS) begin
                mon_p = sbq.pop_front();
                check($sformatf("timeout %h-%h done", mon_p.v.a, mon_p.v.b), {63'b0, done}, 64'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nop = '{16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        //          a         b         diff      bout  ovfl  zero  neg
        tbl[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef SUB_SAT_EN
        tbl[3] = '{16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{16'h0000, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{16'h8000, 16'h7FFF, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        tbl[3] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
        tbl[5] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{16'hABCD, 16'h1234, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b1};

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1 check("reset_state {busy,done,diff,bout,ovfl,zero,neg}",
                 {42'b0, busy, done, diff, bout, ovfl, zero, neg}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, one at a time.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, tbl[i]);
            drain();
        end

        // Table vectors back-to-back, then start held with operands changing each cycle.
        for (int i = 0; i < 9; i++) step(1'b1, tbl[i]);
        for (int i = 0; i < 40; i++) step(1'b1, model(16'($urandom), 16'($urandom)));
        drain();

        // start while busy must neither resample operands nor disturb the result.
        step(1'b1, tbl[8]);
        step(1'b1, model(16'h5555, 16'h1111));
        step(1'b1, model(16'h0F0F, 16'hF0F0));
        drain();

        // Reset after two nibbles: outputs clear with no clock edge.
        step(1'b1, tbl[4]);
        step(1'b0, nop);
        step(1'b0, nop);
        #2 rst_n = 1'b0;
        #1 check("reset_mid {busy,done,diff,bout,ovfl,zero,neg}",
                 {42'b0, busy, done, diff, bout, ovfl, zero, neg}, 64'd0);
        sbq.delete();
        model_run = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, '{16'h00FF, 16'h000F, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
